// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, types and helpers for the multi-port
//                register file (regfile_mp) and its busy scoreboard.
//  Contents    : DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH default geometry,
//                busy_vec_t scoreboard vector for the default geometry,
//                slice_lo() offset helper for flattened port buses.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   // Default geometry: matches the fixed 32x32 file this block replaces.
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

   // Limits on the number of read ports, checked at elaboration.
   localparam int MIN_NUM_RD = 1;
   localparam int MAX_NUM_RD = 4;

   // Scoreboard vector for the default geometry (one bit per entry).
   typedef logic [DEF_DEPTH-1:0] busy_vec_t;

   // Low bit of field 'idx' in a flattened bus made of 'w'-bit fields,
   // e.g. port i of rd_addr lives at [slice_lo(i, ADDR_W) +: ADDR_W].
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-entry busy bits. A reservation (issue) sets the bit for
//                its destination, a writeback clears it. When both hit the
//                same entry at one edge the reservation wins, because the
//                newly issued producer is still outstanding.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                set_en / set_addr  - reservation strobe and entry
//                clr_en / clr_addr  - writeback strobe and entry
//                busy_vec           - DEPTH-bit scoreboard state
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set_en,
   input  logic [ADDR_W-1:0]      set_addr,
   input  logic                   clr_en,
   input  logic [ADDR_W-1:0]      clr_addr,
   output logic [(1<<ADDR_W)-1:0] busy_vec
);

   localparam int DEPTH = 1 << ADDR_W;

   logic w_set_ok;
   logic w_clr_ok;

   // With a hardwired zero register, entry 0 never becomes busy.
   assign w_set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));
   assign w_clr_ok = clr_en;

   for (genvar e = 0; e < DEPTH; e++) begin : g_bit
      logic w_set_hit;
      logic w_clr_hit;
      logic r_busy;

      assign w_set_hit = w_set_ok && (set_addr == ADDR_W'(e));
      assign w_clr_hit = w_clr_ok && (clr_addr == ADDR_W'(e));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_busy <= 1'b0;
         end else if (w_set_hit) begin
            // Set has priority: the new producer overrides the writeback.
            r_busy <= 1'b1;
         end else if (w_clr_hit) begin
            r_busy <= 1'b0;
         end
      end

      assign busy_vec[e] = r_busy;
   end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised register file with NUM_RD combinational read
//                ports, one synchronous write port, optional hardwired zero
//                register, optional same-cycle write-to-read bypass and a
//                per-entry busy scoreboard (reserve at issue, clear at
//                writeback).
//  Ports       : clk, rst_n              - clock, async active-low reset
//                rd_addr  [NUM_RD*ADDR_W] - read addresses, port i at
//                                           [i*ADDR_W +: ADDR_W]
//                rd_data  [NUM_RD*DATA_W] - read data, port i at
//                                           [i*DATA_W +: DATA_W]
//                rd_busy  [NUM_RD]        - busy flag of the addressed entry
//                wr_en / wr_addr / wr_data - writeback port
//                rsv_en / rsv_addr        - destination reservation
//                busy_vec [DEPTH]         - full scoreboard
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [(1<<ADDR_W)-1:0]   busy_vec
);

   localparam int DEPTH = 1 << ADDR_W;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter check
   // ------------------------------------------------------------------------
   if ((NUM_RD < MIN_NUM_RD) || (NUM_RD > MAX_NUM_RD)) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..4");
   end

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_ok;

   // Writes to the hardwired zero register are dropped so entry 0 stays 0.
   assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) begin
            r_mem[e] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Busy scoreboard
   // ------------------------------------------------------------------------
   logic [DEPTH-1:0] w_busy;

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (rsv_en),
      .set_addr (rsv_addr),
      .clr_en   (wr_en),
      .clr_addr (wr_addr),
      .busy_vec (w_busy)
   );

   assign busy_vec = w_busy;

   // ------------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      localparam int A_LO = slice_lo(i, ADDR_W);
      localparam int D_LO = slice_lo(i, DATA_W);

      logic [ADDR_W-1:0] w_addr;
      logic              w_is_zero;
      logic              w_byp;
      logic              w_rsv_hit;
      logic [DATA_W-1:0] w_data;
      logic              w_busy_rd;

      assign w_addr    = rd_addr[A_LO +: ADDR_W];
      assign w_is_zero = (ZERO_REG != 0) && (w_addr == '0);

      // Bypass and the same-cycle reservation override are qualified with
      // rst_n so that the combinational read path shows 0 / not-busy for
      // the whole time reset is held, even if wr_en or rsv_en are active.
      assign w_byp     = (BYPASS != 0) && rst_n && wr_en &&
                         (w_addr == wr_addr) && !w_is_zero;
      assign w_rsv_hit = rst_n && rsv_en && (rsv_addr == w_addr);

      always_comb begin
         w_data    = r_mem[w_addr];
         w_busy_rd = w_busy[w_addr];
         if (w_is_zero) begin
            w_data    = '0;
            w_busy_rd = 1'b0;
         end else if (w_byp) begin
            // The value being written is already the architectural result;
            // the entry only stays busy if a new producer claims it now.
            w_data    = wr_data;
            w_busy_rd = w_rsv_hit;
         end
      end

      assign rd_data[D_LO +: DATA_W] = w_data;
      assign rd_busy[i]              = w_busy_rd;
   end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed self-checking bench for regfile_mp. Three
//                instances: default (bypass, zero reg), a variant with
//                BYPASS=0/ZERO_REG=0 sharing the same stimulus, and a
//                DATA_W=16/ADDR_W=3/NUM_RD=4 variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

   logic clk;
   logic rst_n;

   // Shared stimulus for instances a (default) and b (no bypass, no zero reg)
   logic [9:0]  rd_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;

   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic [31:0] a_busy_vec;
   logic [63:0] b_rd_data;
   logic [1:0]  b_rd_busy;
   logic [31:0] b_busy_vec;

   // Stimulus for instance c (16-bit, 8 entries, 4 read ports)
   logic [11:0] c_rd_addr;
   logic [63:0] c_rd_data;
   logic [3:0]  c_rd_busy;
   logic        c_wr_en;
   logic [2:0]  c_wr_addr;
   logic [15:0] c_wr_data;
   logic        c_rsv_en;
   logic [2:0]  c_rsv_addr;
   logic [7:0]  c_busy_vec;

   int checks   = 0;
   int failures = 0;

   regfile_mp u_a (
      .clk (clk), .rst_n (rst_n),
      .rd_addr (rd_addr), .rd_data (a_rd_data), .rd_busy (a_rd_busy),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rsv_en (rsv_en), .rsv_addr (rsv_addr), .busy_vec (a_busy_vec)
   );

   regfile_mp #(.BYPASS (0), .ZERO_REG (0)) u_b (
      .clk (clk), .rst_n (rst_n),
      .rd_addr (rd_addr), .rd_data (b_rd_data), .rd_busy (b_rd_busy),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rsv_en (rsv_en), .rsv_addr (rsv_addr), .busy_vec (b_busy_vec)
   );

   regfile_mp #(.DATA_W (16), .ADDR_W (3), .NUM_RD (4)) u_c (
      .clk (clk), .rst_n (rst_n),
      .rd_addr (c_rd_addr), .rd_data (c_rd_data), .rd_busy (c_rd_busy),
      .wr_en (c_wr_en), .wr_addr (c_wr_addr), .wr_data (c_wr_data),
      .rsv_en (c_rsv_en), .rsv_addr (c_rsv_addr), .busy_vec (c_busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 2 time units later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n      = 1'b1;
      rd_addr    = '0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      rsv_en     = 1'b0;
      rsv_addr   = '0;
      c_rd_addr  = '0;
      c_wr_en    = 1'b0;
      c_wr_addr  = '0;
      c_wr_data  = '0;
      c_rsv_en   = 1'b0;
      c_rsv_addr = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_a_rd_data", a_rd_data, 64'h0);
      chk("reset_a_busy_vec", {32'h0, a_busy_vec}, 64'h0);
      chk("reset_a_rd_busy", {62'h0, a_rd_busy}, 64'h0);
      step();
      step();
      rst_n = 1'b1;

      // Write r5 and reserve r6, then reset mid-cycle.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      rsv_en = 1'b1; rsv_addr = 5'd6;
      step();
      wr_en = 1'b0; rsv_en = 1'b0;
      rd_addr = {5'd0, 5'd5};
      #1;
      chk("r5_written", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
      chk("r6_busy_before_reset", {32'h0, a_busy_vec}, 64'h40);
      rst_n = 1'b0;
      #1;
      chk("reset_async_r5_a", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("reset_async_r5_b", {32'h0, b_rd_data[31:0]}, 64'h0);
      chk("reset_async_busy_vec", {32'h0, a_busy_vec}, 64'h0);

      // Write and reservation presented while in reset must be discarded.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55555555;
      rsv_en = 1'b1; rsv_addr = 5'd5;
      #1;
      chk("reset_no_bypass", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("reset_no_rd_busy", {62'h0, a_rd_busy}, 64'h0);
      step();
      wr_en = 1'b0; rsv_en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("reset_write_dropped", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("reset_rsv_dropped", {32'h0, a_busy_vec}, 64'h0);

      // Plain write then read on both ports.
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
      step();
      wr_en = 1'b0;
      rd_addr = {5'd7, 5'd7};
      #1;
      chk("r7_port0", {32'h0, a_rd_data[31:0]}, 64'h12345678);
      chk("r7_port1", {32'h0, a_rd_data[63:32]}, 64'h12345678);
      chk("r7_rd_busy", {62'h0, a_rd_busy}, 64'h0);

      // Bypass vs no bypass.
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
      step();
      wr_data = 32'hAA;
      rd_addr = {5'd7, 5'd3};
      #1;
      chk("bypass_on", {32'h0, a_rd_data[31:0]}, 64'hAA);
      chk("bypass_off", {32'h0, b_rd_data[31:0]}, 64'h11);
      chk("bypass_rd_busy", {63'h0, a_rd_busy[0]}, 64'h0);
      step();
      wr_en = 1'b0;
      #1;
      chk("bypass_off_after_edge", {32'h0, b_rd_data[31:0]}, 64'hAA);

      // Scoreboard: reserve r9, release by write three edges later.
      rsv_en = 1'b1; rsv_addr = 5'd9;
      rd_addr = {5'd0, 5'd9};
      #1;
      chk("rsv_not_yet_busy", {63'h0, a_rd_busy[0]}, 64'h0);
      step();
      rsv_en = 1'b0;
      #1;
      chk("rsv_busy_n1", {63'h0, a_rd_busy[0]}, 64'h1);
      chk("rsv_busy_vec", {32'h0, a_busy_vec}, 64'h200);
      step();
      step();
      chk("rsv_still_busy", {63'h0, a_rd_busy[0]}, 64'h1);
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      #1;
      chk("wb_bypass_clears_rd_busy", {63'h0, a_rd_busy[0]}, 64'h0);
      chk("wb_nobypass_still_busy", {63'h0, b_rd_busy[0]}, 64'h1);
      step();
      wr_en = 1'b0;
      #1;
      chk("wb_cleared_rd_busy", {63'h0, a_rd_busy[0]}, 64'h0);
      chk("wb_cleared_busy_vec", {32'h0, a_busy_vec}, 64'h0);
      chk("wb_data", {32'h0, a_rd_data[31:0]}, 64'h99);

      // Same-edge reserve + write to r9: data updates, busy ends at 1.
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      #1;
      chk("same_cycle_rsv_overrides_bypass", {63'h0, a_rd_busy[0]}, 64'h1);
      step();
      wr_en = 1'b0; rsv_en = 1'b0;
      #1;
      chk("same_edge_data", {32'h0, a_rd_data[31:0]}, 64'h77);
      chk("same_edge_busy", {63'h0, a_rd_busy[0]}, 64'h1);
      chk("same_edge_busy_vec", {32'h0, a_busy_vec}, 64'h200);

      // Reserve r10 and write r11 at one edge: both take effect.
      wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hB0B;
      rsv_en = 1'b1; rsv_addr = 5'd10;
      step();
      wr_en = 1'b0; rsv_en = 1'b0;
      rd_addr = {5'd11, 5'd10};
      #1;
      chk("diff_addr_busy_vec", {32'h0, a_busy_vec}, 64'h600);
      chk("diff_addr_write", {32'h0, a_rd_data[63:32]}, 64'hB0B);
      chk("diff_addr_rd_busy", {62'h0, a_rd_busy}, 64'h1);

      // Zero register.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      rd_addr = {5'd0, 5'd0};
      #1;
      chk("zero_no_bypass", {32'h0, a_rd_data[31:0]}, 64'h0);
      chk("zero_no_rd_busy", {62'h0, a_rd_busy}, 64'h0);
      step();
      wr_en = 1'b0; rsv_en = 1'b0;
      #1;
      chk("zero_reads_0", a_rd_data, 64'h0);
      chk("zero_busy_vec0", {63'h0, a_busy_vec[0]}, 64'h0);
      chk("nozero_reads_written", {32'h0, b_rd_data[31:0]}, 64'hFFFFFFFF);
      chk("nozero_busy_vec0", {63'h0, b_busy_vec[0]}, 64'h1);

      // 16-bit / 8-entry / 4-port instance.
      c_wr_en = 1'b1;
      for (int e = 0; e < 8; e++) begin
         c_wr_addr = 3'(e);
         c_wr_data = 16'(16'h1111 * (e + 1));
         step();
      end
      c_wr_en = 1'b0;
      c_rd_addr = {3'd6, 3'd1, 3'd7, 3'd2};
      #1;
      chk("p4_set1", c_rd_data, {16'h7777, 16'h2222, 16'h8888, 16'h3333});
      chk("p4_set1_busy", {60'h0, c_rd_busy}, 64'h0);
      c_rd_addr = {3'd5, 3'd4, 3'd3, 3'd0};
      #1;
      chk("p4_set2_zero_reg", c_rd_data, {16'h6666, 16'h5555, 16'h4444, 16'h0000});
      chk("p4_busy_vec", {56'h0, c_busy_vec}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile_mp
`default_nettype wire
